// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: drives PC/nPC/IF-ID load enables, the nPC source select
// and the IF/ID NOP insert, with post-reset boot delay, sticky halt and fetch counter.
module if_fetch_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic             stall_req,
  input  logic             jmpl_req,
  input  logic             branch_taken,
  input  logic             annul_ds,
  input  logic             halt_req,
  output logic             pc_le,
  output logic             npc_le,
  output logic             ifid_le,
  output logic             ch_clear,
  output logic [1:0]       npc_sel,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  // BOOT_CYCLES of 0 and 1 both leave BOOT on the first edge after release.
  localparam logic [BW-1:0] BOOT_LAST = (BOOT_CYCLES > 0) ? BW'(BOOT_CYCLES - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic [BW-1:0]    r_boot_cnt;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_fetch;

  always_comb begin
    pc_le    = 1'b0;
    npc_le   = 1'b0;
    ifid_le  = 1'b0;
    ch_clear = 1'b1;
    npc_sel  = 2'b00;
    w_next   = r_state;
    case (r_state)
      S_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) w_next = S_RUN;
      end
      // STALL only differs from RUN by its debug encoding; requests are serviced identically.
      S_RUN, S_STALL: begin
        if (halt_req) begin
          w_next = S_HALT;
        end else if (stall_req) begin
          ch_clear = 1'b0;
          w_next   = S_STALL;
        end else begin
          pc_le    = 1'b1;
          npc_le   = 1'b1;
          ifid_le  = 1'b1;
          ch_clear = annul_ds;
          if (jmpl_req)          npc_sel = 2'b01;
          else if (branch_taken) npc_sel = 2'b10;
          w_next = S_RUN;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
    endcase
  end

  assign w_fetch = ifid_le & ~ch_clear;

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_BOOT && r_boot_cnt != BOOT_LAST)
        r_boot_cnt <= r_boot_cnt + BW'(1);
      if (w_fetch && r_fetch_count != '1)
        r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign fetch_count = r_fetch_count;
  assign ctrl_state  = r_state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: two instances (boot 2/16-bit count, boot 0/4-bit count)
// driven in lockstep and compared against a cycle-level behavioural model.
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  logic R = 1'b0;
  logic stall_req = 1'b0, jmpl_req = 1'b0, branch_taken = 1'b0, annul_ds = 1'b0, halt_req = 1'b0;

  logic        pc0, npc0, ifid0, clr0;
  logic [1:0]  sel0, st0;
  logic [15:0] cnt0;
  logic        pc1, npc1, ifid1, clr1;
  logic [1:0]  sel1, st1;
  logic [3:0]  cnt1;

  if_fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .R(R), .stall_req(stall_req), .jmpl_req(jmpl_req),
    .branch_taken(branch_taken), .annul_ds(annul_ds), .halt_req(halt_req),
    .pc_le(pc0), .npc_le(npc0), .ifid_le(ifid0), .ch_clear(clr0),
    .npc_sel(sel0), .fetch_count(cnt0), .ctrl_state(st0)
  );

  if_fetch_ctrl #(.BOOT_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .R(R), .stall_req(stall_req), .jmpl_req(jmpl_req),
    .branch_taken(branch_taken), .annul_ds(annul_ds), .halt_req(halt_req),
    .pc_le(pc1), .npc_le(npc1), .ifid_le(ifid1), .ch_clear(clr1),
    .npc_sel(sel1), .fetch_count(cnt1), .ctrl_state(st1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  ctl0;
    logic [15:0] cnt0;
    logic [1:0]  st0;
    logic [5:0]  ctl1;
    logic [3:0]  cnt1;
    logic [1:0]  st1;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Model: mode 0=boot 1=run 2=stall 3=halt; boot ends after max(BOOT_CYCLES,1) edges.
  int m_mode[2];
  int m_elapsed[2];
  int m_cnt[2];
  int m_bc[2];
  int m_max[2];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ctl0",   {10'd0, pc0, npc0, ifid0, clr0, sel0}, {10'd0, e.ctl0});
      chk("count0", cnt0, e.cnt0);
      chk("state0", {14'd0, st0}, {14'd0, e.st0});
      chk("ctl1",   {10'd0, pc1, npc1, ifid1, clr1, sel1}, {10'd0, e.ctl1});
      chk("count1", {12'd0, cnt1}, {12'd0, e.cnt1});
      chk("state1", {14'd0, st1}, {14'd0, e.st1});
    end
  end

  task automatic step(input bit r, input bit st, input bit jm, input bit br,
                      input bit an, input bit ha);
    logic [5:0] ctl[2];
    int         cnt[2];
    int         mode[2];
    int         nxt;
    exp_t       e;
    @(posedge clk);
    #1;
    R = r; stall_req = st; jmpl_req = jm; branch_taken = br; annul_ds = an; halt_req = ha;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_mode[i] = 0; m_elapsed[i] = 0; m_cnt[i] = 0;
      end
      nxt = m_mode[i];
      if (m_mode[i] == 0 || m_mode[i] == 3) begin
        ctl[i] = 6'b000100;
        if (m_mode[i] == 0 && m_elapsed[i] + 1 >= ((m_bc[i] > 1) ? m_bc[i] : 1)) nxt = 1;
      end else if (ha) begin
        ctl[i] = 6'b000100; nxt = 3;
      end else if (st) begin
        ctl[i] = 6'b000000; nxt = 2;
      end else begin
        ctl[i] = {3'b111, an, jm ? 2'b01 : (br ? 2'b10 : 2'b00)}; nxt = 1;
      end
      cnt[i]  = m_cnt[i];
      mode[i] = m_mode[i];
      if (r) begin
        if (ctl[i][3] && !ctl[i][2] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        if (m_mode[i] == 0) m_elapsed[i]++;
        m_mode[i] = nxt;
      end
    end
    e.ctl0 = ctl[0]; e.cnt0 = 16'(cnt[0]); e.st0 = 2'(mode[0]);
    e.ctl1 = ctl[1]; e.cnt1 = 4'(cnt[1]);  e.st1 = 2'(mode[1]);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_bc[0] = 2;  m_max[0] = 65535;
    m_bc[1] = 0;  m_max[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_elapsed[i] = 0; m_cnt[i] = 0;
    end

    repeat (3) step(0, 0, 0, 0, 0, 0);
    idle(4);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 1, 1, 0);
    idle(1);
    step(1, 0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    idle(20);
    step(0, 0, 0, 0, 0, 0);
    idle(5);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 1, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0);
    idle(4);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 149) == 0);
    end

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
